// File: rtl/reg_share_arbiter.sv
// Four-requester round-robin arbiter guarding one shared WIDTH-bit register.
// Each transaction runs IDLE -> GRANT -> DONE. Requesters whose req drops during GRANT are aborted.
module reg_share_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] wdata,
  output logic [3:0]         gnt,
  output logic [3:0]         ack,
  output logic [WIDTH-1:0]   q,
  output logic               busy,
  output logic [1:0]         owner
);

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         owner_q, owner_d;
  logic [3:0]         gnt_q, gnt_d;
  logic [3:0]         ack_q, ack_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [1:0]         pick_idx;
  logic [1:0]         cand;
  logic [WIDTH-1:0]   owner_data;

  // Scan from ptr+3 down to ptr so the last hit is the first set bit in round-robin order.
  always_comb begin
    pick_idx = ptr_q;
    cand     = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (req[cand]) begin
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (owner_q == 2'(i)) begin
        owner_data = wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = '0;
    ack_d   = '0;
    q_d     = q_q;
    case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StGrant;
          gnt_d   = 4'b0001 << pick_idx;
          owner_d = pick_idx;
        end
      end
      StGrant: begin
        // The pointer advances past the owner whether the write lands or is aborted.
        ptr_d = owner_q + 2'd1;
        if (req[owner_q]) begin
          q_d     = owner_data;
          ack_d   = 4'b0001 << owner_q;
          state_d = StDone;
        end else begin
          state_d = StIdle;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= 2'd0;
      owner_q <= 2'd0;
      gnt_q   <= '0;
      ack_q   <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
    end
  end

  assign gnt   = gnt_q;
  assign ack   = ack_q;
  assign q     = q_q;
  assign owner = owner_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: doc/reg_share_arbiter.md
REG_SHARE_ARBITER -- requirements
Module: reg_share_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of the shared register and of each requester's write data.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port req, input, 4 bits: req[i] high means requester i wants to write the shared register.
REQ-005 SHALL have port wdata, input, 4*WIDTH bits: requester i's data is on bits [i*WIDTH +: WIDTH].
REQ-006 SHALL have port gnt, output, 4 bits: registered, one-hot or zero; gnt[i] high means requester i owns the register this cycle.
REQ-007 SHALL have port ack, output, 4 bits: registered, one-hot or zero; one-cycle pulse confirming that requester i's write landed.
REQ-008 SHALL have port q, output, WIDTH bits: registered shared register contents.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-010 SHALL have port owner, output, 2 bits: index of the most recent grant, held between grants.

Function
REQ-011 SHALL implement a 3-state FSM with states IDLE, GRANT and DONE.
REQ-012 IDLE: if any req bit is high at the clock edge, SHALL move to GRANT; otherwise SHALL stay in IDLE.
- On the IDLE->GRANT edge, SHALL select one requester g by round-robin.
- On the same edge, SHALL register gnt = one-hot(g) and owner = g.
REQ-013 Round-robin SHALL search req starting at pointer ptr, in order ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first set bit wins.
REQ-014 GRANT lasts exactly one cycle; on the edge ending GRANT, if req[g] is still high, SHALL:
- load q <= wdata slice g;
- set ack[g] = 1;
- move to DONE.
REQ-015 On the edge ending GRANT, if req[g] has dropped (abort), SHALL leave q unchanged, assert no ack, and move to IDLE.
REQ-016 DONE lasts exactly one cycle with ack[g] high, then SHALL move to IDLE with ack cleared.
REQ-017 gnt SHALL be high only during the GRANT cycle; gnt and ack SHALL never be high in the same cycle.
REQ-018 ptr SHALL become (g+1) mod 4 on the edge leaving GRANT, for both a write and an abort.
REQ-019 Latency from req sampled in IDLE: gnt 1 cycle later, q/ack 2 cycles later; maximum throughput is one write per 3 cycles.
REQ-020 req changes during GRANT for requesters other than g, and all req changes during DONE, SHALL have no effect until the next IDLE sample.
REQ-021 A requester holding req high continuously SHALL be granted at most once per 3-cycle window.
- With all 4 requesting, it SHALL be granted again within 12 cycles (no starvation).
REQ-022 wdata SHALL be sampled only on the edge ending GRANT.
REQ-023 q SHALL change only on a completed write.

Reset
REQ-024 While rst_n is low, asynchronously and regardless of clk, SHALL force:
- state = IDLE, ptr = 0;
- gnt = 0, ack = 0, q = 0, owner = 0;
- busy = 0.
REQ-025 Reset asserted during GRANT or DONE SHALL discard the transaction: no write, no ack.
REQ-026 After rst_n rises, the first req sample SHALL occur on the next rising clk edge.

Verification
REQ-027 Single write: WIDTH=8, req=0001, slice0=0xA5 held 3 cycles.
- Expected: gnt=0001 on cycle 1; q=0xA5 and ack=0001 on cycle 2; busy=0 on cycle 3.
REQ-028 Round-robin: req=1111 held, slices 0x11/0x22/0x33/0x44.
- Expected grant order 0,1,2,3,0; q sequence 0x11,0x22,0x33,0x44.
- Expected ack every 3rd cycle.
REQ-029 Wrap: after a grant to requester 3, req=1001 -> requester 0 is granted next, then 3.
REQ-030 Abort: req=0100 drops during GRANT.
- Expected: q unchanged, ack=0000, next grant search starts at requester 3.
REQ-031 Mid-operation reset: rst_n pulsed low during DONE.
- Expected: immediately gnt=ack=0, q=0, busy=0; after release with req=0010, grant goes to requester 1 (ptr=0 search).
REQ-032 Sampling: req[2] rises during GRANT for requester 0 -> ignored that cycle, granted at the next IDLE sample; wdata changes during DONE do not alter q.
